// File: rtl/avalon_sram_arbiter.sv
// rtl/avalon_sram_arbiter.sv - m0 read-priority / m1 write arbiter for one Avalon SRAM controller port
// Optional feature macro SRAM_ARB_STATS_EN adds accept/stall statistics counters.
module avalon_sram_arbiter #(
  parameter int AVN_AW       = 18,
  parameter int AVN_DW       = 16,
  parameter int RD_LATENCY   = 2,
  parameter int TURN_CYCLES  = 1,
  parameter int MAX_RD_BURST = 8
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  m0_avn_read,
  input  logic [AVN_AW-1:0]     m0_avn_address,
  output logic                  m0_avn_waitrequest,
  output logic [AVN_DW-1:0]     m0_avn_readdata,
  output logic                  m0_avn_readdatavalid,
  input  logic                  m1_avn_write,
  input  logic [AVN_AW-1:0]     m1_avn_address,
  input  logic [AVN_DW-1:0]     m1_avn_writedata,
  input  logic [AVN_DW/8-1:0]   m1_avn_byteenable,
  output logic                  m1_avn_waitrequest,
`ifdef SRAM_ARB_STATS_EN
  input  logic                  stat_clr,
  output logic [31:0]           stat_rd_cnt,
  output logic [31:0]           stat_wr_cnt,
  output logic [31:0]           stat_stall_cnt,
`endif
  output logic                  sram_avn_read,
  output logic                  sram_avn_write,
  output logic [AVN_AW-1:0]     sram_avn_address,
  output logic [AVN_DW-1:0]     sram_avn_writedata,
  output logic [AVN_DW/8-1:0]   sram_avn_byteenable,
  input  logic [AVN_DW-1:0]     sram_avn_readdata
);

  localparam int CW = $clog2(MAX_RD_BURST + 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       rd_cnt;
  logic [1:0]          turn_cnt;
  logic                wr_done;
  logic [RD_LATENCY:0] rd_pipe;
  logic                m0_acc, m1_acc;
  logic                burst_full, turn_zero;

  assign burst_full = (rd_cnt == CW'(MAX_RD_BURST));
  assign turn_zero  = (turn_cnt == '0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // Grants are decided here; waitrequest is simply the inverse of the grant.
  always_comb begin
    state_nxt = state;
    m0_acc    = 1'b0;
    m1_acc    = 1'b0;
    case (state)
      IDLE: begin
        if (m0_avn_read) begin
          m0_acc    = 1'b1;
          state_nxt = READ;
        end else if (m1_avn_write && turn_zero) begin
          m1_acc    = 1'b1;
          state_nxt = WRITE;
        end
      end
      READ: begin
        if (m1_avn_write && (!m0_avn_read || burst_full)) state_nxt = WRITE;
        else if (m0_avn_read)                             m0_acc    = 1'b1;
        else                                              state_nxt = IDLE;
      end
      WRITE: begin
        if (wr_done && m0_avn_read) begin
          m0_acc    = 1'b1;
          state_nxt = READ;
        end else if (m1_avn_write && turn_zero) begin
          m1_acc    = 1'b1;
        end else if (!m0_avn_read && !m1_avn_write) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!sys_rst_n) begin
      m0_acc = 1'b0;
      m1_acc = 1'b0;
    end
  end

  always_comb begin
    m0_avn_waitrequest = !m0_acc;
    m1_avn_waitrequest = !m1_acc;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_cnt   <= '0;
      turn_cnt <= '0;
      wr_done  <= 1'b0;
    end else begin
      if (m0_acc) begin
        turn_cnt <= 2'(TURN_CYCLES);
        if (!burst_full) rd_cnt <= rd_cnt + 1'b1;
      end else begin
        if (!turn_zero) turn_cnt <= turn_cnt - 1'b1;
        if (m1_acc || (state == READ && state_nxt != READ)) rd_cnt <= '0;
      end
      if (m1_acc)      wr_done <= 1'b1;
      else if (m0_acc) wr_done <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sram_avn_read       <= 1'b0;
      sram_avn_write      <= 1'b0;
      sram_avn_address    <= '0;
      sram_avn_writedata  <= '0;
      sram_avn_byteenable <= '0;
    end else begin
      sram_avn_read       <= m0_acc;
      sram_avn_write      <= m1_acc;
      sram_avn_address    <= m0_acc ? m0_avn_address : (m1_acc ? m1_avn_address : '0);
      sram_avn_writedata  <= m1_acc ? m1_avn_writedata : '0;
      sram_avn_byteenable <= m1_acc ? m1_avn_byteenable : '0;
    end
  end

  // Tag pipe: the last stage is readdatavalid; data is captured as the tag enters it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_pipe         <= '0;
      m0_avn_readdata <= '0;
    end else begin
      rd_pipe <= {rd_pipe[RD_LATENCY-1:0], m0_acc};
      if (rd_pipe[RD_LATENCY-1]) m0_avn_readdata <= sram_avn_readdata;
    end
  end

  assign m0_avn_readdatavalid = rd_pipe[RD_LATENCY];

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else if (stat_clr) begin
      stat_rd_cnt    <= '0;
      stat_wr_cnt    <= '0;
      stat_stall_cnt <= '0;
    end else begin
      if (m0_acc) stat_rd_cnt <= stat_rd_cnt + 32'd1;
      if (m1_acc) stat_wr_cnt <= stat_wr_cnt + 32'd1;
      if ((m0_avn_read && !m0_acc) || (m1_avn_write && !m1_acc))
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
